serial_subtractor_ctrl: RTL

Bit-serial multi-bit subtractor controller. It takes two WIDTH-bit operands on a start pulse and sequences a single full-subtractor cell LSB-first, one bit per clock, through a registered borrow flip-flop. It then presents the difference and final borrow with a one-cycle done pulse. It is the sequencing layer that turns the team's 1-bit full-subtractor datapath into a WIDTH-bit arithmetic unit for the lab designs.

---
 rtl/subtractor_pkg.sv | 12 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor controller.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int WIDTH_MAX = 32;

endpackage : subtractor_pkg

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, bout set when the subtraction underflows.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_cell

// File: rtl/serial_subtractor_ctrl.sv
// Sequences one full-subtractor cell LSB-first over WIDTH clocks and presents
// the registered difference and final borrow with a one-cycle done pulse.
module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor_ctrl: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bf;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor_cell u_cell (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (bf),
    .d   (cell_d),
    .bout(cell_bo)
  );

  // NOTE: every register here, the operand/result shift registers included,
  // is cleared by rst so an aborted operation leaves no stale bits behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      bf     <= 1'b0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the cell sees this
      // cycle's sa/sb/bf while their next values are being scheduled.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            bf    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bf  <= cell_bo;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {cell_d, sr[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          // Last bit: publish the whole word at once, never a partial result.
          if (cnt == CNT_LAST) begin
            diff   <= {cell_d, sr[WIDTH-1:1]};
            borrow <= cell_bo;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor_ctrl
